// File: rtl/buffer_tx_scheduler.sv
// -----------------------------------------------------------------------------
// buffer_tx_scheduler
//
// Shares the thermometer's valid-entry FIFO between the sample producer (writes)
// and the UART transmit path (read-then-clear). A one-entry pending register
// holds a sample until the FIFO can take it. A small FSM sends the FIFO head,
// waits for the UART to finish, and then clears that entry. If the UART does
// not finish in time, the FSM resends the entry a limited number of times and
// then abandons it.
//
// Handshake semantics (sample_valid/sample_ready, tx_valid/tx_ready): a
// transfer happens on a rising edge where valid and ready are both high.
// Valid never depends on ready. Once valid is raised, it and its data stay
// stable until the transfer happens.
//
// Ports
//   clk, reset         : clock, asynchronous active-low reset
//   sample_valid/ready : producer handshake, sample_data payload
//   fifo_write         : FIFO push strobe, fifo_wr_data = pending register
//   fifo_read          : FIFO pop/clear strobe (one cycle in CLEAR)
//   fifo_full/empty    : FIFO flags, fifo_rd_data = combinational head entry
//   tx_valid/tx_ready  : UART handshake, tx_data payload
//   tx_done            : one-cycle pulse, UART finished the accepted entry
//   err_count          : abandoned entries, saturates at 255
//   busy               : FSM not idle or pending sample held
//   dbg_state          : current FSM state (IDLE=0 SEND=1 WAIT_DONE=2 CLEAR=3)
// -----------------------------------------------------------------------------
module buffer_tx_scheduler #(
   parameter int DW        = 7,
   parameter int TIMEOUT   = 1000,
   parameter int MAX_RETRY = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sample_valid,
   input  logic [DW:0]   sample_data,
   output logic          sample_ready,
   output logic          fifo_write,
   output logic [DW:0]   fifo_wr_data,
   output logic          fifo_read,
   input  logic          fifo_full,
   input  logic          fifo_empty,
   input  logic [DW:0]   fifo_rd_data,
   output logic          tx_valid,
   output logic [DW:0]   tx_data,
   input  logic          tx_ready,
   input  logic          tx_done,
   output logic [7:0]    err_count,
   output logic          busy,
   output logic [1:0]    dbg_state
);

   localparam int TW = $clog2(TIMEOUT);
   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SEND      = 2'd1,
      WAIT_DONE = 2'd2,
      CLEAR     = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            pend_valid_q, pend_valid_d;
   logic [DW:0]     pend_data_q, pend_data_d;
   logic [DW:0]     tx_data_q, tx_data_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [7:0]      err_q, err_d;

   // Pending register and write grant. CLEAR always wins over a pending write,
   // so a write that would collide with a clear simply waits one cycle.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_data_d  = pend_data_q;
      sample_ready = !pend_valid_q;
      fifo_write   = pend_valid_q && !fifo_full && (state_q != CLEAR);
      fifo_wr_data = pend_data_q;

      // A load and a grant cannot coincide: a load needs an empty register,
      // and a grant needs a full one.
      if (fifo_write) begin
         pend_valid_d = 1'b0;
      end
      if (sample_valid && sample_ready) begin
         pend_valid_d = 1'b1;
         pend_data_d  = sample_data;
      end
   end

   // TX FSM: next state and outputs.
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      timer_d   = timer_q;
      retry_d   = retry_q;
      err_d     = err_q;
      tx_valid  = 1'b0;
      fifo_read = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               tx_data_d = fifo_rd_data;
               retry_d   = '0;
               state_d   = SEND;
            end
         end
         SEND: begin
            tx_valid = 1'b1;
            if (tx_ready) begin
               timer_d = '0;
               state_d = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_done) begin
               state_d = CLEAR;
            end else if (timer_q == TIMER_LAST) begin
               if (retry_q < RETRY_MAX) begin
                  // Resend the same captured entry. The timer restarts on the next accept.
                  retry_d = retry_q + 1'b1;
                  state_d = SEND;
               end else begin
                  if (err_q != 8'hFF) begin
                     err_d = err_q + 8'd1;
                  end
                  state_d = CLEAR;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         CLEAR: begin
            fifo_read = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         tx_data_q    <= '0;
         timer_q      <= '0;
         retry_q      <= '0;
         err_q        <= '0;
      end else begin
         state_q      <= state_d;
         pend_valid_q <= pend_valid_d;
         pend_data_q  <= pend_data_d;
         tx_data_q    <= tx_data_d;
         timer_q      <= timer_d;
         retry_q      <= retry_d;
         err_q        <= err_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign err_count = err_q;
   assign busy      = (state_q != IDLE) || pend_valid_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_buffer_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_buffer_tx_scheduler
//
// Directed test of buffer_tx_scheduler (TIMEOUT=8, MAX_RETRY=2) driving a
// small behavioural 8-entry FIFO. The scoreboard queue holds every sample
// offered, in order, and is matched against each FIFO write.
// -----------------------------------------------------------------------------
module tb_buffer_tx_scheduler;

   localparam int DW        = 7;
   localparam int TIMEOUT   = 8;
   localparam int MAX_RETRY = 2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SEND  = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_CLEAR = 2'd3;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic          sample_valid;
   logic [DW:0]   sample_data;
   logic          sample_ready;
   logic          fifo_write;
   logic [DW:0]   fifo_wr_data;
   logic          fifo_read;
   logic          fifo_full;
   logic          fifo_empty;
   logic [DW:0]   fifo_rd_data;
   logic          tx_valid;
   logic [DW:0]   tx_data;
   logic          tx_ready;
   logic          tx_done;
   logic [7:0]    err_count;
   logic          busy;
   logic [1:0]    dbg_state;

   buffer_tx_scheduler #(
      .DW        (DW),
      .TIMEOUT   (TIMEOUT),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .sample_ready (sample_ready),
      .fifo_write   (fifo_write),
      .fifo_wr_data (fifo_wr_data),
      .fifo_read    (fifo_read),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .fifo_rd_data (fifo_rd_data),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_ready     (tx_ready),
      .tx_done      (tx_done),
      .err_count    (err_count),
      .busy         (busy),
      .dbg_state    (dbg_state)
   );

   // ---------------- behavioural FIFO ----------------
   logic [DW:0] f_mem [8];
   logic [2:0]  f_wr = '0;
   logic [2:0]  f_rd = '0;
   int          f_cnt = 0;
   logic        full_force;

   assign fifo_full    = full_force || (f_cnt == 8);
   assign fifo_empty   = (f_cnt == 0);
   assign fifo_rd_data = f_mem[f_rd];

   always @(posedge clk) begin
      if (fifo_write) begin
         f_mem[f_wr] <= fifo_wr_data;
         f_wr        <= f_wr + 3'd1;
      end
      if (fifo_read && f_cnt != 0) begin
         f_rd <= f_rd + 3'd1;
      end
      f_cnt <= f_cnt + (fifo_write ? 1 : 0) - ((fifo_read && f_cnt != 0) ? 1 : 0);
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [DW:0] exp_q [$];
   int wr_cnt   = 0;
   int rd_cnt   = 0;
   int hs_cnt   = 0;
   int both_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         if (fifo_write) begin
            wr_cnt <= wr_cnt + 1;
            if (exp_q.size() == 0) begin
               check("wr_unexpected", 32'(fifo_wr_data), 32'hFFFF_FFFF);
            end else begin
               check("wr_data", 32'(fifo_wr_data), 32'(exp_q.pop_front()));
            end
         end
         if (fifo_read)              rd_cnt   <= rd_cnt + 1;
         if (tx_valid && tx_ready)   hs_cnt   <= hs_cnt + 1;
         if (fifo_write && fifo_read) both_cnt <= both_cnt + 1;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_state(input logic [1:0] st, input string tag);
      int n;
      n = 0;
      while (dbg_state != st && n < 200) begin
         tick();
         n++;
      end
      check(tag, 32'(dbg_state), 32'(st));
   endtask

   // Offer one sample. The transfer takes place on the first edge where sample_ready is high.
   task automatic offer(input logic [DW:0] d);
      int n;
      sample_data  = d;
      sample_valid = 1'b1;
      exp_q.push_back(d);
      n = 0;
      while (!sample_ready && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("offer_timeout", 32'(sample_ready), 32'd1);
      tick();
      sample_valid = 1'b0;
   endtask

   // Complete one transmission of the FIFO head, which is expected to be d.
   task automatic finish_tx(input logic [DW:0] d, input string tag);
      wait_state(S_SEND, {tag, "_send"});
      check({tag, "_txdata"}, 32'(tx_data), 32'(d));
      tick();
      check({tag, "_wait"}, 32'(dbg_state), 32'(S_WAIT));
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check({tag, "_clear"}, 32'(dbg_state), 32'(S_CLEAR));
      check({tag, "_rd"}, 32'(fifo_read), 32'd1);
      check({tag, "_wr_excl"}, 32'(fifo_write), 32'd0);
      tick();
      check({tag, "_idle"}, 32'(dbg_state), 32'(S_IDLE));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- directed tests ----------------
   initial begin
      int wr0, rd0, hs0;
      reset        = 1'b0;
      sample_valid = 1'b0;
      sample_data  = '0;
      full_force   = 1'b0;
      tx_ready     = 1'b1;
      tx_done      = 1'b0;
      tick();
      tick();

      // Reset values
      check("rst_state",   32'(dbg_state),   32'(S_IDLE));
      check("rst_ready",   32'(sample_ready), 32'd1);
      check("rst_write",   32'(fifo_write),  32'd0);
      check("rst_read",    32'(fifo_read),   32'd0);
      check("rst_txvalid", 32'(tx_valid),    32'd0);
      check("rst_txdata",  32'(tx_data),     32'd0);
      check("rst_err",     32'(err_count),   32'd0);
      check("rst_busy",    32'(busy),        32'd0);
      reset = 1'b1;
      tick();

      // 1: single sample 0x2A end to end
      wr0 = wr_cnt; rd0 = rd_cnt;
      offer(8'h2A);
      check("t1_write",   32'(fifo_write),   32'd1);
      check("t1_wrdata",  32'(fifo_wr_data), 32'h2A);
      check("t1_ready0",  32'(sample_ready), 32'd0);
      tick();
      check("t1_idle",    32'(dbg_state),    32'(S_IDLE));
      check("t1_nowrite", 32'(fifo_write),   32'd0);
      tick();
      check("t1_send",    32'(dbg_state),    32'(S_SEND));
      check("t1_txvalid", 32'(tx_valid),     32'd1);
      check("t1_txdata",  32'(tx_data),      32'h2A);
      tick();
      tick();
      tick();
      check("t1_waiting", 32'(dbg_state),    32'(S_WAIT));
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      check("t1_clear",   32'(fifo_read),    32'd1);
      check("t1_wr_excl", 32'(fifo_write),   32'd0);
      tick();
      check("t1_back",    32'(dbg_state),    32'(S_IDLE));
      check("t1_busy",    32'(busy),         32'd0);
      check("t1_err",     32'(err_count),    32'd0);
      check("t1_nwr",     32'(wr_cnt - wr0), 32'd1);
      check("t1_nrd",     32'(rd_cnt - rd0), 32'd1);

      // 2: FIFO full holds the sample. tx_done outside WAIT_DONE is ignored.
      full_force = 1'b1;
      wr0 = wr_cnt;
      offer(8'h55);
      check("t2_ready0",  32'(sample_ready), 32'd0);
      check("t2_blocked", 32'(fifo_write),   32'd0);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      repeat (8) tick();
      check("t2_idle",    32'(dbg_state),    32'(S_IDLE));
      check("t2_nowr",    32'(wr_cnt - wr0), 32'd0);
      check("t2_held",    32'(sample_ready), 32'd0);
      check("t2_busy",    32'(busy),         32'd1);
      full_force = 1'b0;
      #1;
      check("t2_release", 32'(fifo_write),   32'd1);
      check("t2_wrdata",  32'(fifo_wr_data), 32'h55);
      finish_tx(8'h55, "t2");

      // 3: a pending write collides with CLEAR and is deferred by one cycle
      offer(8'h11);
      wait_state(S_SEND, "t3_send");
      tick();
      check("t3_wait", 32'(dbg_state), 32'(S_WAIT));
      tx_done      = 1'b1;
      sample_valid = 1'b1;
      sample_data  = 8'h99;
      exp_q.push_back(8'h99);
      tick();
      tx_done      = 1'b0;
      sample_valid = 1'b0;
      check("t3_clear_rd", 32'(fifo_read),    32'd1);
      check("t3_clear_wr", 32'(fifo_write),   32'd0);
      check("t3_pending",  32'(sample_ready), 32'd0);
      tick();
      check("t3_def_wr",   32'(fifo_write),   32'd1);
      check("t3_def_rd",   32'(fifo_read),    32'd0);
      check("t3_def_data", 32'(fifo_wr_data), 32'h99);
      finish_tx(8'h99, "t3b");

      // 4: timeout and retry, tx_done never arrives
      rd0 = rd_cnt;
      offer(8'h3C);
      wait_state(S_SEND, "t4_send");
      hs0 = hs_cnt;
      tick();
      check("t4_wait",   32'(dbg_state), 32'(S_WAIT));
      repeat (TIMEOUT - 1) tick();
      check("t4_hold",   32'(dbg_state), 32'(S_WAIT));
      tick();
      check("t4_retry",  32'(dbg_state), 32'(S_SEND));
      check("t4_same",   32'(tx_data),   32'h3C);
      wait_state(S_CLEAR, "t4_clear");
      check("t4_sends",  32'(hs_cnt - hs0), 32'd3);
      check("t4_err",    32'(err_count),    32'd1);
      check("t4_rd",     32'(fifo_read),    32'd1);
      tick();
      check("t4_idle",   32'(dbg_state),    32'(S_IDLE));
      check("t4_nrd",    32'(rd_cnt - rd0), 32'd1);

      // 5: reset in WAIT_DONE abandons the entry without a clear
      offer(8'h77);
      wait_state(S_WAIT, "t5_wait");
      rd0 = rd_cnt;
      reset = 1'b0;
      #1;
      check("t5_state",   32'(dbg_state), 32'(S_IDLE));
      check("t5_txvalid", 32'(tx_valid),  32'd0);
      check("t5_txdata",  32'(tx_data),   32'd0);
      check("t5_read",    32'(fifo_read), 32'd0);
      check("t5_err",     32'(err_count), 32'd0);
      check("t5_busy",    32'(busy),      32'd0);
      tick();
      tick();
      check("t5_nord",    32'(rd_cnt - rd0), 32'd0);
      reset = 1'b1;
      finish_tx(8'h77, "t5");

      // 6: error counter saturation
      for (int i = 0; i < 300; i++) begin
         offer(8'(i));
         wait_state(S_CLEAR, "t6_clear");
         tick();
         if (i == 99)  check("t6_err100", 32'(err_count), 32'd100);
         if (i == 254) check("t6_err255", 32'(err_count), 32'd255);
      end
      check("t6_sat", 32'(err_count), 32'd255);

      // Run-wide properties
      tick();
      check("never_both",  32'(both_cnt),     32'd0);
      check("sb_drained",  32'(exp_q.size()), 32'd0);
      check("wr_eq_rd",    32'(wr_cnt),       32'(rd_cnt));
      check("fifo_empty",  32'(fifo_empty),   32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/buffer_tx_scheduler.md
# buffer_tx_scheduler

Single-port sequencer that sits in front of the thermometer's valid-entry FIFO and shares it between the sample producer (writes) and the UART transmit path (read-then-clear). It guarantees the FIFO never sees a write and a clear in the same cycle, holds one blocked sample, and drives a send / wait-for-done / clear loop with timeout and retry.

## Interface
- DW, 7: MSB index of sample/FIFO data (data width DW+1).
- TIMEOUT, 1000: cycles in WAIT_DONE before a retry; minimum 2.
- MAX_RETRY, 3: resends before an entry is abandoned.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sample_valid  in  1  producer has a sample.
- sample_data  in  DW+1  sample value.
- sample_ready  out  1  sample accepted this cycle when high with sample_valid.
- fifo_write  out  1  FIFO write strobe.
- fifo_wr_data  out  DW+1  FIFO write data (= pending register).
- fifo_read  out  1  FIFO clear/pop strobe.
- fifo_full  in  1  FIFO full flag.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rd_data  in  DW+1  FIFO head entry (combinational read).
- tx_valid  out  1  tx_data valid for UART.
- tx_data  out  DW+1  entry being transmitted.
- tx_ready  in  1  UART accepts tx_data when high with tx_valid.
- tx_done  in  1  one-cycle pulse: UART finished sending the accepted entry.
- err_count  out  8  abandoned entries, saturates at 255.
- busy  out  1  high when tx FSM not in IDLE or pending register full.

## Operation
- Pending register (pend_valid, pend_data): loaded from sample_data when sample_valid && sample_ready. sample_ready = !pend_valid (registered, no combinational path from FIFO flags).
- Write grant: fifo_write = pend_valid && !fifo_full && (state != CLEAR). On grant pend_valid clears at the next edge. fifo_wr_data = pend_data at all times.
- Clear has priority: in CLEAR, fifo_read = 1 and fifo_write = 0 regardless of pend_valid. fifo_write and fifo_read are never high together.
- TX FSM states: IDLE, SEND, WAIT_DONE, CLEAR.
  - IDLE: if !fifo_empty, capture tx_data <= fifo_rd_data, retry_cnt <= 0, go SEND.
  - SEND: tx_valid = 1; on tx_ready go WAIT_DONE, timer <= 0.
  - WAIT_DONE: tx_done -> CLEAR. Otherwise timer increments; at timer == TIMEOUT-1: if retry_cnt < MAX_RETRY, retry_cnt++ and go SEND (same tx_data); else err_count++ (saturating) and go CLEAR.
  - CLEAR: fifo_read high for exactly one cycle, then IDLE.
- tx_valid is high only in SEND; tx_data is stable from IDLE exit until return to IDLE.
- tx_done outside WAIT_DONE is ignored.
- Timer width: $clog2(TIMEOUT); retry_cnt width: $clog2(MAX_RETRY+1).
- Pending register and tx FSM run independently; a sample may be held while the FSM is mid-transmit.

## Timing
- Reset (reset low): state IDLE, pend_valid 0, pend_data 0, tx_data 0, tx_valid 0, fifo_write 0, fifo_read 0, timer 0, retry_cnt 0, err_count 0, busy 0, sample_ready 1 after release. Reset mid-transmit abandons the entry without clearing the FIFO and without counting an error.
- Sample to FIFO write: sample accepted at edge N -> fifo_write high in cycle N+1 if not full and not in CLEAR.
- Full FIFO: pend_valid stays 1, sample_ready 0, no data loss; write issues the first cycle fifo_full is low and state != CLEAR.
- CLEAR coinciding with pending write: write deferred exactly one cycle.
- FIFO non-empty to tx_valid: one cycle (IDLE sample, SEND next cycle).
- tx handshake to clear: tx_done at cycle M -> fifo_read high in cycle M+1 -> IDLE at M+2; next entry (if any) in SEND at M+3.
- Timeout: WAIT_DONE entered at edge T, no tx_done -> SEND again at edge T+TIMEOUT.

## Test plan
- Single sample 0x2A into empty FIFO, tx_ready tied 1, tx_done 3 cycles after accept -> one fifo_write with 0x2A, tx_data 0x2A, one fifo_read, err_count 0.
- fifo_full=1 for 10 cycles with sample 0x55 offered -> sample_ready 0 after accept, no fifo_write, fifo_write in first cycle after full drops, data 0x55.
- Pending write and CLEAR in same cycle -> fifo_read alone that cycle, fifo_write next cycle; never both high (assertion across run).
- TIMEOUT=8, MAX_RETRY=2, tx_done never -> three SEND phases for same tx_data, then one fifo_read, err_count 1.
- Reset asserted in WAIT_DONE -> all outputs at reset values immediately; no fifo_read issued; after release, IDLE re-sends FIFO head.
- 300 abandoned entries (tx_done never) -> err_count saturates at 255.
